// File: rtl/can_fd_payload_rx_if.sv
// rtl/can_fd_payload_rx_if.sv - frame-control, bit-stream and byte-write signals of the CAN FD payload receiver
interface can_fd_payload_rx_if #(
  parameter int MAX_BYTES = 64
) ();
  localparam int AW = $clog2(MAX_BYTES);

  logic          start_i;
  logic [3:0]    dlc_i;
  logic          fd_i;
  logic          rtr_i;
  logic          bit_valid_i;
  logic          bit_i;
  logic          abort_i;
  logic [6:0]    data_len_o;
  logic          len_clip_o;
  logic          crc_sel_o;
  logic          crc21_o;
  logic          byte_we_o;
  logic [AW-1:0] byte_addr_o;
  logic [7:0]    byte_data_o;
  logic [6:0]    byte_cnt_o;
  logic          busy_o;
  logic          data_done_o;

  modport master (
    output start_i, dlc_i, fd_i, rtr_i, bit_valid_i, bit_i, abort_i,
    input  data_len_o, len_clip_o, crc_sel_o, crc21_o, byte_we_o, byte_addr_o,
           byte_data_o, byte_cnt_o, busy_o, data_done_o
  );

  modport slave (
    input  start_i, dlc_i, fd_i, rtr_i, bit_valid_i, bit_i, abort_i,
    output data_len_o, len_clip_o, crc_sel_o, crc21_o, byte_we_o, byte_addr_o,
           byte_data_o, byte_cnt_o, busy_o, data_done_o
  );
endinterface

// File: rtl/can_fd_payload_rx.sv
// rtl/can_fd_payload_rx.sv - CAN FD data-field receiver: DLC decode, length clamp, CRC select, MSB-first byte assembly
module can_fd_payload_rx #(
  parameter int FD_EN     = 1,
  parameter int MAX_BYTES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  can_fd_payload_rx_if.slave bus
);
  localparam int AW = $clog2(MAX_BYTES);
  localparam logic [6:0] MAX_LEN = 7'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [6:0]    byte_cnt_q, byte_cnt_d;
  logic [6:0]    len_q, len_d;
  logic          clip_q, clip_d;
  logic          crc_sel_q, crc_sel_d;
  logic          crc21_q, crc21_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          fd_eff;
  logic [6:0]    raw_len;

  // Unclamped length; FD frames have no remote form, so RTR only zeroes classic frames.
  always_comb begin
    fd_eff  = (FD_EN != 0) && bus.fd_i;
    raw_len = 7'd0;
    if (bus.dlc_i <= 4'd8) begin
      raw_len = {3'd0, bus.dlc_i};
    end else if (!fd_eff) begin
      raw_len = 7'd8;
    end else begin
      case (bus.dlc_i)
        4'd9:    raw_len = 7'd12;
        4'd10:   raw_len = 7'd16;
        4'd11:   raw_len = 7'd20;
        4'd12:   raw_len = 7'd24;
        4'd13:   raw_len = 7'd32;
        4'd14:   raw_len = 7'd48;
        default: raw_len = 7'd64;
      endcase
    end
    if (bus.rtr_i && !fd_eff) raw_len = 7'd0;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    clip_d     = clip_q;
    crc_sel_d  = crc_sel_q;
    crc21_d    = crc21_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    if (bus.abort_i) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      shift_d    = 8'd0;
      byte_cnt_d = 7'd0;
    end else if (bus.start_i) begin
      clip_d     = raw_len > MAX_LEN;
      len_d      = clip_d ? MAX_LEN : raw_len;
      crc21_d    = fd_eff && (raw_len > 7'd16);
      crc_sel_d  = fd_eff && (raw_len <= 7'd16);
      bit_cnt_d  = 3'd0;
      shift_d    = 8'd0;
      byte_cnt_d = 7'd0;
      state_d    = (len_d == 7'd0) ? DONE : DATA;
    end else begin
      case (state_q)
        DATA: begin
          if (bus.bit_valid_i) begin
            shift_d   = {shift_q[6:0], bus.bit_i};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              we_d       = 1'b1;
              data_d     = shift_d;
              addr_d     = byte_cnt_q[AW-1:0];
              byte_cnt_d = byte_cnt_q + 7'd1;
              if (byte_cnt_d == len_q) state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      byte_cnt_q <= 7'd0;
      len_q      <= 7'd0;
      clip_q     <= 1'b0;
      crc_sel_q  <= 1'b0;
      crc21_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      clip_q     <= clip_d;
      crc_sel_q  <= crc_sel_d;
      crc21_q    <= crc21_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // DONE is entered exactly when the final byte strobe (or the empty-frame decision) is registered.
  assign bus.data_len_o  = len_q;
  assign bus.len_clip_o  = clip_q;
  assign bus.crc_sel_o   = crc_sel_q;
  assign bus.crc21_o     = crc21_q;
  assign bus.byte_we_o   = we_q;
  assign bus.byte_addr_o = addr_q;
  assign bus.byte_data_o = data_q;
  assign bus.byte_cnt_o  = byte_cnt_q;
  assign bus.busy_o      = (state_q == DATA);
  assign bus.data_done_o = (state_q == DONE);
endmodule

// File: tb/tb_can_fd_payload_rx.sv
// tb/tb_can_fd_payload_rx.sv - scoreboard bench driving three configurations of can_fd_payload_rx with one stimulus stream
module tb_can_fd_payload_rx;
  typedef struct {int a; int b; int c; int d;} rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, fd_r = 1'b0, rtr_r = 1'b0, bv = 1'b0, bt = 1'b0, abort = 1'b0;
  logic [3:0] dlc_r = 4'd0;
  logic hdr_pend = 1'b0, abort_pend = 1'b0;
  int n_cmp = 0, n_fail = 0;

  int fd_tab[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};
  int cfg_fd[3]  = '{1, 1, 0};
  int cfg_max[3] = '{64, 8, 64};
  int last_len[3] = '{0, 0, 0};
  rec_t hdr_q[3][$];
  rec_t byte_q[3][$];
  rec_t done_q[3][$];

  always #5 clk = ~clk;

  can_fd_payload_rx_if #(.MAX_BYTES(64)) if0 ();
  can_fd_payload_rx_if #(.MAX_BYTES(8))  if1 ();
  can_fd_payload_rx_if #(.MAX_BYTES(64)) if2 ();

  assign if0.start_i = start; assign if0.dlc_i = dlc_r; assign if0.fd_i = fd_r; assign if0.rtr_i = rtr_r;
  assign if0.bit_valid_i = bv; assign if0.bit_i = bt; assign if0.abort_i = abort;
  assign if1.start_i = start; assign if1.dlc_i = dlc_r; assign if1.fd_i = fd_r; assign if1.rtr_i = rtr_r;
  assign if1.bit_valid_i = bv; assign if1.bit_i = bt; assign if1.abort_i = abort;
  assign if2.start_i = start; assign if2.dlc_i = dlc_r; assign if2.fd_i = fd_r; assign if2.rtr_i = rtr_r;
  assign if2.bit_valid_i = bv; assign if2.bit_i = bt; assign if2.abort_i = abort;

  can_fd_payload_rx #(.FD_EN(1), .MAX_BYTES(64)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  can_fd_payload_rx #(.FD_EN(1), .MAX_BYTES(8))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  can_fd_payload_rx #(.FD_EN(0), .MAX_BYTES(64)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic string nm(string s, int i);
    return $sformatf("%s[dut%0d]", s, i);
  endfunction

  // Length/CRC rules straight from the DLC table, independent of any FSM.
  function automatic void ref_hdr(int fd_en, int maxb, int dlc, int fd, int rtr,
                                  output int len, output int clip, output int crc);
    int raw;
    bit fde;
    fde = (fd_en != 0) && (fd != 0);
    raw = fde ? fd_tab[dlc] : ((dlc > 8) ? 8 : dlc);
    if (rtr != 0 && !fde) raw = 0;
    clip = (raw > maxb) ? 1 : 0;
    len  = (raw > maxb) ? maxb : raw;
    crc  = !fde ? 0 : ((raw <= 16) ? 1 : 2);
  endfunction

  always @(posedge clk) begin
    hdr_pend   <= rst_n && start && !abort;
    abort_pend <= rst_n && abort;
  end

  task automatic mon(int i, logic we, int addr, int data, int cnt, logic done,
                     int len, logic clip, int crc, logic busy);
    rec_t r;
    if (hdr_pend) begin
      if (hdr_q[i].size() == 0) chk(nm("hdr_queue_size", i), 0, 1);
      else begin
        r = hdr_q[i].pop_front();
        chk(nm("data_len", i), len, r.a);
        chk(nm("len_clip", i), int'(clip), r.b);
        chk(nm("crc_code", i), crc, r.c);
        chk(nm("byte_cnt_at_start", i), cnt, 0);
        chk(nm("busy_at_start", i), int'(busy), (r.a != 0) ? 1 : 0);
      end
    end
    if (abort_pend) begin
      chk(nm("abort_busy", i), int'(busy), 0);
      chk(nm("abort_byte_cnt", i), cnt, 0);
      chk(nm("abort_we", i), int'(we), 0);
      chk(nm("abort_done", i), int'(done), 0);
      chk(nm("abort_len_held", i), len, last_len[i]);
    end
    if (we) begin
      if (byte_q[i].size() == 0) chk(nm("unexpected_byte_we_addr", i), addr, -1);
      else begin
        r = byte_q[i].pop_front();
        chk(nm("byte_addr", i), addr, r.a);
        chk(nm("byte_data", i), data, r.b);
        chk(nm("byte_cnt_after_we", i), cnt, r.a + 1);
      end
    end
    if (done) begin
      if (done_q[i].size() == 0) chk(nm("unexpected_done_cnt", i), cnt, -1);
      else begin
        r = done_q[i].pop_front();
        chk(nm("done_len", i), len, r.a);
        chk(nm("done_byte_cnt", i), cnt, r.b);
      end
    end
  endtask

  always @(negedge clk) if (rst_n) mon(0, if0.byte_we_o, int'(if0.byte_addr_o), int'(if0.byte_data_o),
      int'(if0.byte_cnt_o), if0.data_done_o, int'(if0.data_len_o), if0.len_clip_o,
      int'({if0.crc21_o, if0.crc_sel_o}), if0.busy_o);
  always @(negedge clk) if (rst_n) mon(1, if1.byte_we_o, int'(if1.byte_addr_o), int'(if1.byte_data_o),
      int'(if1.byte_cnt_o), if1.data_done_o, int'(if1.data_len_o), if1.len_clip_o,
      int'({if1.crc21_o, if1.crc_sel_o}), if1.busy_o);
  always @(negedge clk) if (rst_n) mon(2, if2.byte_we_o, int'(if2.byte_addr_o), int'(if2.byte_data_o),
      int'(if2.byte_cnt_o), if2.data_done_o, int'(if2.data_len_o), if2.len_clip_o,
      int'({if2.crc21_o, if2.crc_sel_o}), if2.busy_o);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero();
    chk("reset_outputs[dut0]", $countones({if0.data_len_o, if0.len_clip_o, if0.crc_sel_o, if0.crc21_o,
        if0.byte_we_o, if0.byte_addr_o, if0.byte_data_o, if0.byte_cnt_o, if0.busy_o, if0.data_done_o}), 0);
    chk("reset_outputs[dut1]", $countones({if1.data_len_o, if1.len_clip_o, if1.crc_sel_o, if1.crc21_o,
        if1.byte_we_o, if1.byte_addr_o, if1.byte_data_o, if1.byte_cnt_o, if1.busy_o, if1.data_done_o}), 0);
    chk("reset_outputs[dut2]", $countones({if2.data_len_o, if2.len_clip_o, if2.crc_sel_o, if2.crc21_o,
        if2.byte_we_o, if2.byte_addr_o, if2.byte_data_o, if2.byte_cnt_o, if2.busy_o, if2.data_done_o}), 0);
  endtask

  // kind: 0 = leave frame (complete or restarted by the next start), 1 = abort after the bits, 2 = reset after the bits
  task automatic frame(int dlc, int fd, int rtr, int nbits, int kind, int pat);
    logic [7:0] pl [72];
    int len, clip, crc;
    for (int j = 0; j < 72; j++) pl[j] = (pat < 0) ? 8'($urandom) : 8'(pat);
    cyc();
    start = 1'b1; dlc_r = 4'(dlc); fd_r = fd[0]; rtr_r = rtr[0]; abort = 1'b0;
    bv = 1'($urandom_range(1)); bt = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      ref_hdr(cfg_fd[i], cfg_max[i], dlc, fd, rtr, len, clip, crc);
      hdr_q[i].push_back(rec_t'{len, clip, crc, 0});
      last_len[i] = len;
      for (int j = 0; j < len && j < nbits / 8; j++) byte_q[i].push_back(rec_t'{j, int'(pl[j]), 0, 0});
      if (len == 0 || nbits >= 8 * len) done_q[i].push_back(rec_t'{len, len, 0, 0});
    end
    for (int b = 0; b < nbits; b++) begin
      cyc();
      start = 1'b0;
      if ($urandom_range(3) == 0) begin
        bv = 1'b0;
        cyc();
      end
      bv = 1'b1;
      bt = pl[b / 8][7 - (b % 8)];
    end
    cyc();
    start = 1'b0; bv = 1'b0;
    if (kind == 1) begin
      abort = 1'b1;
      cyc();
      abort = 1'b0;
    end else if (kind == 2) begin
      cyc();
      #2 rst_n = 1'b0;
      #1 check_zero();
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) last_len[i] = 0;
    end else begin
      repeat ($urandom_range(2)) cyc();
    end
  endtask

  initial begin
    int dlc, fd, rtr, mode, l0, c0, r0, nb;
    repeat (3) cyc();
    check_zero();
    rst_n = 1'b1;

    frame(8, 0, 0, 64, 0, 8'hA5);
    frame(13, 1, 0, 32 * 8 + 5, 0, -1);
    frame(10, 1, 0, 16 * 8, 0, -1);
    frame(15, 1, 0, 64 * 8 + 16, 0, -1);
    frame(4, 0, 1, 40, 0, -1);
    frame(8, 0, 0, 24, 1, -1);
    frame(1, 0, 0, 8, 0, -1);
    frame(12, 1, 0, 48 * 8, 0, -1);
    frame(15, 1, 1, 100, 2, -1);
    frame(2, 0, 0, 16, 0, -1);
    frame(0, 1, 0, 0, 0, -1);

    for (int k = 0; k < 60; k++) begin
      dlc  = $urandom_range(15);
      fd   = $urandom_range(1);
      rtr  = ($urandom_range(3) == 0) ? 1 : 0;
      mode = $urandom_range(3);
      ref_hdr(1, 64, dlc, fd, rtr, l0, c0, r0);
      nb = (mode < 2) ? 8 * l0 + $urandom_range(12) : $urandom_range(8 * l0);
      frame(dlc, fd, rtr, nb, (mode == 2 || mode == 1) ? 1 : 0, -1);
    end

    repeat (5) cyc();
    for (int i = 0; i < 3; i++) begin
      chk(nm("leftover_hdr", i), hdr_q[i].size(), 0);
      chk(nm("leftover_bytes", i), byte_q[i].size(), 0);
      chk(nm("leftover_done", i), done_q[i].size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/can_fd_payload_rx.md
CAN_FD_PAYLOAD_RX -- requirements
Module: can_fd_payload_rx

Interface
Parameters
REQ-001 The block SHALL have parameter FD_EN, default 1, meaning 1 = FD DLC decoding enabled and 0 = classic decoding only (fd_i ignored).
REQ-002 The block SHALL have parameter MAX_BYTES, default 64, legal values 8..64, meaning payload buffer depth in bytes.
REQ-003 The block SHALL have derived localparam AW = clog2(MAX_BYTES), meaning the byte-address width.

Ports
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port start_i, input, 1 bit: a one-cycle pulse at the end of the DLC field that latches dlc_i, fd_i and rtr_i.
REQ-007 The block SHALL have port dlc_i, input, 4 bits: the received Data Length Code.
REQ-008 The block SHALL have port fd_i, input, 1 bit: 1 = FD frame (FDF/EDL recessive).
REQ-009 The block SHALL have port rtr_i, input, 1 bit: 1 = remote frame, which carries no data field.
REQ-010 The block SHALL have port bit_valid_i, input, 1 bit: qualifies bit_i with one destuffed data bit per assertion.
REQ-011 The block SHALL have port bit_i, input, 1 bit: the data bit, MSB of each byte first.
REQ-012 The block SHALL have port abort_i, input, 1 bit: error or bus-off abort of the current frame.
REQ-013 The block SHALL have port data_len_o, output, 7 bits: the decoded payload length in bytes, held until the next start_i.
REQ-014 The block SHALL have port len_clip_o, output, 1 bit: 1 = the decoded length exceeded MAX_BYTES and was clamped.
REQ-015 The block SHALL have port crc_sel_o, output, 1 bit: 0 = CRC-15 (classic), 1 = CRC-17 (FD, length ≤ 16), 2 = CRC-21 (FD, length > 16); crc_sel_o SHALL be the LSB of that code and crc21_o SHALL be its MSB.
REQ-016 The block SHALL have port crc21_o, output, 1 bit: as defined in REQ-015.
REQ-017 The block SHALL have port byte_we_o, output, 1 bit: a one-cycle write strobe.
REQ-018 The block SHALL have port byte_addr_o, output, AW bits: the byte index, 0-based.
REQ-019 The block SHALL have port byte_data_o, output, 8 bits: the assembled byte.
REQ-020 The block SHALL have port byte_cnt_o, output, 7 bits: the number of bytes written so far in the frame.
REQ-021 The block SHALL have port busy_o, output, 1 bit: high in the DATA state.
REQ-022 The block SHALL have port data_done_o, output, 1 bit: a one-cycle pulse when the data field is complete.

Function
REQ-023 Decoding SHALL be as follows:
- DLC 0..8 SHALL decode to 0..8.
- When FD_EN=1 and fd_i=1, DLC 9..15 SHALL decode to 12, 16, 20, 24, 32, 48, 64.
- Otherwise, DLC 9..15 SHALL decode to 8.
- When rtr_i=1 and fd_i=0, the length SHALL be 0.
- When rtr_i=1 and fd_i=1, rtr_i SHALL be ignored, because FD has no remote frames.
REQ-024 Clamping: when the decoded length exceeds MAX_BYTES, data_len_o SHALL be MAX_BYTES and len_clip_o SHALL be 1; both SHALL be registered on the cycle after start_i.
REQ-025 CRC selection SHALL be derived from the unclamped length and SHALL be registered with data_len_o.
REQ-026 The FSM SHALL have three states: IDLE, DATA and DONE.
REQ-027 IDLE SHALL transition on start_i to DATA when the length is nonzero, and to DONE when the length is 0.
REQ-028 DATA SHALL shift bit_i into an 8-bit register MSB-first on each bit_valid_i, counting bits 0..7.
REQ-029 In DATA, on the 8th valid bit, the next cycle SHALL show:
- byte_we_o = 1;
- byte_data_o = the assembled byte;
- byte_addr_o = byte_cnt_o (the pre-increment value);
- byte_cnt_o then incrementing.
REQ-030 DATA SHALL transition to DONE when the final byte is written, and data_done_o SHALL assert in the same cycle as that final byte_we_o.
REQ-031 On the zero-length path, data_done_o SHALL assert on the cycle after start_i and byte_we_o SHALL never assert.
REQ-032 DONE SHALL last one cycle and then return to IDLE.
REQ-033 bit_valid_i in IDLE or DONE SHALL be ignored.
REQ-034 Bits received beyond the decoded length SHALL be ignored.
REQ-035 start_i in DATA or DONE SHALL restart the frame: the bit and byte counters SHALL be cleared, new values latched, and no data_done_o issued for the old frame.
REQ-036 abort_i SHALL have priority over start_i and bit_valid_i: the FSM SHALL go to IDLE, the counters SHALL clear, no byte_we_o or data_done_o SHALL occur, and data_len_o SHALL be held.
REQ-037 start_i and bit_valid_i in the same cycle SHALL be resolved in favour of start_i, with the bit discarded.

Reset
REQ-038 While rst_n=0, asynchronously:
- the FSM SHALL be in IDLE;
- all outputs SHALL be 0, including data_len_o, byte_cnt_o, byte_addr_o and byte_data_o;
- the bit counter and shift register SHALL be 0.
REQ-039 Reset de-assertion SHALL take effect on the next clk rising edge; the first start_i SHALL be honoured one cycle after rst_n rises.
REQ-040 Reset asserted mid-frame SHALL abandon the frame with no data_done_o.

Verification
REQ-041 Scenario: classic, dlc=8, fd=0, 64 bits of 0xA5 -> data_len_o=8, crc code 0, eight byte_we_o with data 0xA5 at addr 0..7, data_done_o with the 8th write.
REQ-042 Scenario: FD, dlc=13, MAX_BYTES=64 -> data_len_o=32, crc21_o=1, 32 writes, byte_cnt_o=32 at done; and FD, dlc=10 -> 16 bytes, crc_sel_o=1, crc21_o=0.
REQ-043 Scenario: MAX_BYTES=8, FD, dlc=15 -> data_len_o=8, len_clip_o=1, crc21_o=1, done after 8 bytes, extra bits ignored.
REQ-044 Scenario: dlc=4, rtr=1, fd=0 -> data_len_o=0, data_done_o on the cycle after start_i, no byte_we_o.
REQ-045 Scenario: abort_i after 3 bytes of an 8-byte frame -> IDLE, byte_cnt_o=0, no data_done_o; then a new start_i with dlc=1 completes normally.
REQ-046 Scenario: FD_EN=0, fd_i=1, dlc=12 -> data_len_o=8, crc code 0.
